// File: rtl/mc_controller.sv
// Multi-cycle control FSM for the shared 32-bit datapath (register file, ALU,
// unified memory, PC). Sequences FETCH/DECODE/EXEC/MEM/WB with a mem_ready
// wait-state handshake, counts retired instructions and halts on an illegal
// opcode until reset.
//
// Ports:
//   CLK, RST_N          clock (rising edge), async active-low reset
//   opcode, funct       IR[31:26], IR[5:0]; stable from DECODE until next FETCH
//   isZero              ALU zero flag
//   mem_ready           memory completes the current access this cycle
//   PCWr, IRWr, RegWr   PC / IR / register file write enables
//   MemRd, MemWr        memory read / write requests
//   IorD                memory address select (0 = PC, 1 = ALU result)
//   ALUSrcB, ALUCtrl    ALU operand B select and operation
//   RegDst, MemToReg    register write address / data selects
//   PCSel               next-PC source select
//   state, halted       debug state, HALT indicator
//   retired             retired-instruction count (wraps)
module mc_controller #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned LINK_REG = 31
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             isZero,
  input  logic             mem_ready,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RegWr,
  output logic             MemRd,
  output logic             MemWr,
  output logic             IorD,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUCtrl,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemToReg,
  output logic [1:0]       PCSel,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  // RegDst = 2 selects LINK_REG in the datapath; it must be a 5-bit index.
  if (LINK_REG > 31) begin : g_link_chk
    $error("LINK_REG must be a valid register index (0..31)");
  end

  typedef enum logic [2:0] {
    StFetch  = 3'b000,
    StDecode = 3'b001,
    StExec   = 3'b010,
    StMem    = 3'b011,
    StWb     = 3'b100,
    StHalt   = 3'b111
  } state_e;

  localparam logic [5:0] OpR    = 6'h00;
  localparam logic [5:0] OpJ    = 6'h02;
  localparam logic [5:0] OpJal  = 6'h03;
  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpBne  = 6'h05;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpXori = 6'h0E;
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnSlt = 6'h2A;
  localparam logic [5:0] FnJr  = 6'h08;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluXor = 3'b010;
  localparam logic [2:0] AluSlt = 3'b011;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;

  logic is_r, is_lw, is_sw, is_beq, is_bne, is_addi, is_xori, is_jr, r_ok, exec_ok;
  logic pc_wr, ir_wr, reg_wr, mem_rd, mem_wr;

  assign is_r    = (opcode == OpR);
  assign is_lw   = (opcode == OpLw);
  assign is_sw   = (opcode == OpSw);
  assign is_beq  = (opcode == OpBeq);
  assign is_bne  = (opcode == OpBne);
  assign is_addi = (opcode == OpAddi);
  assign is_xori = (opcode == OpXori);
  assign is_jr   = is_r && (funct == FnJr);
  assign r_ok    = (funct == FnAdd) || (funct == FnSub) || (funct == FnSlt) || (funct == FnJr);
  assign exec_ok = is_lw || is_sw || is_beq || is_bne || is_addi || is_xori || (is_r && r_ok);

  always_comb begin
    state_d  = state_q;
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    reg_wr   = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    IorD     = 1'b0;
    ALUSrcB  = 2'd0;
    ALUCtrl  = AluAdd;
    RegDst   = 2'd0;
    MemToReg = 2'd0;
    PCSel    = 2'd0;
    unique case (state_q)
      StFetch: begin
        mem_rd  = 1'b1;
        ALUSrcB = 2'd3;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (opcode == OpJ) begin
          pc_wr   = 1'b1;
          PCSel   = 2'd2;
          state_d = StFetch;
        end else if (opcode == OpJal) begin
          reg_wr   = 1'b1;
          RegDst   = 2'd2;
          MemToReg = 2'd2;
          pc_wr    = 1'b1;
          PCSel    = 2'd2;
          state_d  = StFetch;
        end else if (exec_ok) begin
          state_d = StExec;
        end else begin
          state_d = StHalt;
        end
      end
      StExec: begin
        state_d = StWb;
        if (is_lw || is_sw || is_addi) begin
          ALUSrcB = 2'd1;
          if (!is_addi) state_d = StMem;
        end else if (is_xori) begin
          ALUCtrl = AluXor;
          ALUSrcB = 2'd2;
        end else if (is_beq || is_bne) begin
          ALUCtrl = AluSub;
          pc_wr   = is_beq ? isZero : !isZero;
          PCSel   = 2'd1;
          state_d = StFetch;
        end else if (is_jr) begin
          pc_wr   = 1'b1;
          PCSel   = 2'd3;
          state_d = StFetch;
        end else if (funct == FnSub) begin
          ALUCtrl = AluSub;
        end else if (funct == FnSlt) begin
          ALUCtrl = AluSlt;
        end
      end
      StMem: begin
        IorD    = 1'b1;
        ALUSrcB = 2'd1;
        mem_rd  = is_lw;
        // Write request stays up through waits; memory commits on mem_ready.
        mem_wr  = is_sw;
        if (mem_ready) state_d = is_lw ? StWb : StFetch;
      end
      StWb: begin
        reg_wr   = 1'b1;
        RegDst   = is_r ? 2'd1 : 2'd0;
        MemToReg = is_lw ? 2'd1 : 2'd0;
        state_d  = StFetch;
      end
      StHalt: ;
      default: state_d = StHalt;
    endcase
  end

  // Enables are gated by reset so an aborted instruction writes nothing.
  assign PCWr   = pc_wr & RST_N;
  assign IRWr   = ir_wr & RST_N;
  assign RegWr  = reg_wr & RST_N;
  assign MemRd  = mem_rd & RST_N;
  assign MemWr  = mem_wr & RST_N;
  assign state  = state_q;
  assign halted = (state_q == StHalt);
  assign retired = retired_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == StFetch && state_q != StFetch) retired_q <= retired_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic        CLK;
  logic        RST_N;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        isZero;
  logic        mem_ready;
  logic        PCWr, IRWr, RegWr, MemRd, MemWr, IorD;
  logic [1:0]  ALUSrcB, RegDst, MemToReg, PCSel;
  logic [2:0]  ALUCtrl, state;
  logic        halted;
  logic [31:0] retired;

  mc_controller #(.CNT_W(32), .LINK_REG(31)) dut (
    .CLK(CLK), .RST_N(RST_N), .opcode(opcode), .funct(funct), .isZero(isZero),
    .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemRd(MemRd),
    .MemWr(MemWr), .IorD(IorD), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl), .RegDst(RegDst),
    .MemToReg(MemToReg), .PCSel(PCSel), .state(state), .halted(halted), .retired(retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0]  st;
    logic        pcwr, irwr, regwr, memrd, memwr, iord;
    logic [1:0]  srcb;
    logic [2:0]  aluc;
    logic [1:0]  regdst, m2r, pcsel;
    logic        hlt;
    logic [31:0] ret;
  } ctl_t;

  localparam int KJ = 0, KJAL = 1, KLW = 2, KSW = 3, KBEQ = 4, KBNE = 5, KADDI = 6,
                 KXORI = 7, KADD = 8, KSUB = 9, KSLT = 10, KJR = 11;

  ctl_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc_no = 0;
  logic [31:0] ret_m = '0;

  // Scoreboard monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge CLK) begin
    ctl_t e, a;
    cyc_no++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {state, PCWr, IRWr, RegWr, MemRd, MemWr, IorD, ALUSrcB, ALUCtrl, RegDst, MemToReg,
           PCSel, halted, retired};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL ctl cycle=%0d act st=%0d pcwr=%b irwr=%b regwr=%b rd=%b wr=%b iord=%b srcb=%0d alu=%0d dst=%0d m2r=%0d pcsel=%0d hlt=%b ret=%0d | exp st=%0d pcwr=%b irwr=%b regwr=%b rd=%b wr=%b iord=%b srcb=%0d alu=%0d dst=%0d m2r=%0d pcsel=%0d hlt=%b ret=%0d",
                 cyc_no, a.st, a.pcwr, a.irwr, a.regwr, a.memrd, a.memwr, a.iord, a.srcb,
                 a.aluc, a.regdst, a.m2r, a.pcsel, a.hlt, a.ret, e.st, e.pcwr, e.irwr,
                 e.regwr, e.memrd, e.memwr, e.iord, e.srcb, e.aluc, e.regdst, e.m2r,
                 e.pcsel, e.hlt, e.ret);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] k_op(input int k);
    case (k)
      KJ:      return 6'h02;
      KJAL:    return 6'h03;
      KLW:     return 6'h23;
      KSW:     return 6'h2B;
      KBEQ:    return 6'h04;
      KBNE:    return 6'h05;
      KADDI:   return 6'h08;
      KXORI:   return 6'h0E;
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [5:0] k_fn(input int k);
    case (k)
      KADD:    return 6'h20;
      KSUB:    return 6'h22;
      KSLT:    return 6'h2A;
      KJR:     return 6'h08;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  // Drive one cycle of inputs (just after the edge) and queue its expected outputs.
  task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic mr,
                     input logic iz, input ctl_t e);
    opcode    = op;
    funct     = fn;
    mem_ready = mr;
    isZero    = iz;
    e.ret     = ret_m;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input int fw);
    ctl_t e;
    e = '0;
    e.memrd = 1'b1;
    e.srcb  = 2'd3;
    for (int i = 0; i < fw; i++) cyc(op, fn, 1'b0, 1'($urandom), e);
    e.irwr = 1'b1;
    e.pcwr = 1'b1;
    cyc(op, fn, 1'b1, 1'($urandom), e);
  endtask

  // izf < 0 means a random isZero in EXEC.
  task automatic run_instr(input int k, input int fw, input int mw, input int izf);
    ctl_t e;
    logic [5:0] op, fn;
    logic iz;
    op = k_op(k);
    fn = k_fn(k);
    fetch(op, fn, fw);
    e = '0;
    e.st = 3'd1;
    if (k == KJ || k == KJAL) begin
      e.pcwr  = 1'b1;
      e.pcsel = 2'd2;
      if (k == KJAL) begin
        e.regwr  = 1'b1;
        e.regdst = 2'd2;
        e.m2r    = 2'd2;
      end
    end
    cyc(op, fn, 1'($urandom), 1'($urandom), e);
    if (k == KJ || k == KJAL) begin
      ret_m++;
      return;
    end
    iz = (izf < 0) ? 1'($urandom) : 1'(izf);
    e = '0;
    e.st = 3'd2;
    case (k)
      KLW, KSW, KADDI: e.srcb = 2'd1;
      KXORI: begin e.srcb = 2'd2; e.aluc = 3'd2; end
      KSUB:  e.aluc = 3'd1;
      KSLT:  e.aluc = 3'd3;
      KBEQ, KBNE: begin
        e.aluc  = 3'd1;
        e.pcsel = 2'd1;
        e.pcwr  = (k == KBEQ) ? iz : !iz;
      end
      KJR: begin e.pcwr = 1'b1; e.pcsel = 2'd3; end
      default: ;
    endcase
    cyc(op, fn, 1'($urandom), iz, e);
    if (k == KBEQ || k == KBNE || k == KJR) begin
      ret_m++;
      return;
    end
    if (k == KLW || k == KSW) begin
      e = '0;
      e.st    = 3'd3;
      e.iord  = 1'b1;
      e.srcb  = 2'd1;
      e.memrd = (k == KLW);
      e.memwr = (k == KSW);
      for (int i = 0; i < mw; i++) cyc(op, fn, 1'b0, 1'($urandom), e);
      cyc(op, fn, 1'b1, 1'($urandom), e);
      if (k == KSW) begin
        ret_m++;
        return;
      end
    end
    e = '0;
    e.st     = 3'd4;
    e.regwr  = 1'b1;
    e.regdst = (k >= KADD) ? 2'd1 : 2'd0;
    e.m2r    = (k == KLW) ? 2'd1 : 2'd0;
    cyc(op, fn, 1'($urandom), 1'($urandom), e);
    ret_m++;
  endtask

  task automatic run_ill(input logic [5:0] op, input logic [5:0] fn, input int n);
    ctl_t e;
    fetch(op, fn, 0);
    e = '0;
    e.st = 3'd1;
    cyc(op, fn, 1'($urandom), 1'($urandom), e);
    e.st  = 3'd7;
    e.hlt = 1'b1;
    for (int i = 0; i < n; i++) begin
      cyc(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'($urandom),
          1'($urandom), e);
    end
  endtask

  // Assert reset mid-cycle with mem_ready high; effects must be immediate.
  task automatic do_reset(input string tag);
    mem_ready = 1'b1;
    RST_N     = 1'b0;
    #1;
    chk({tag, "_state"}, 64'(state), 64'd0);
    chk({tag, "_retired"}, 64'(retired), 64'd0);
    chk({tag, "_enables"}, 64'({PCWr, IRWr, RegWr, MemRd, MemWr}), 64'd0);
    chk({tag, "_halted"}, 64'(halted), 64'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    ret_m = '0;
  endtask

  initial begin
    ctl_t e;
    RST_N     = 1'b0;
    mem_ready = 1'b1;
    opcode    = '0;
    funct     = '0;
    isZero    = 1'b0;
    #2;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_enables", 64'({PCWr, IRWr, RegWr, MemRd, MemWr}), 64'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    run_instr(KADD, 0, 0, -1);
    run_instr(KLW, 2, 3, -1);
    run_instr(KBEQ, 0, 0, 0);
    run_instr(KBNE, 0, 0, 0);
    run_instr(KJAL, 0, 0, -1);
    for (int i = 0; i < 60; i++) begin
      run_instr($urandom_range(0, 11), $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    // Abort an ADD in EXEC.
    fetch(6'h00, 6'h20, 0);
    e = '0;
    e.st = 3'd1;
    cyc(6'h00, 6'h20, 1'b1, 1'b0, e);
    do_reset("abort");
    run_instr(KADD, 0, 0, -1);

    run_ill(6'h3F, 6'($urandom_range(0, 63)), 20);
    do_reset("halt1");
    run_ill(6'h00, 6'h21, 3);
    do_reset("halt2");
    run_instr(KSW, 1, 1, -1);
    run_instr(KJR, 0, 0, -1);

    @(negedge CLK);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
